// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for D: tracks in-flight GRF writes, raises the D stall and reports the forwarding slot.
// Optional feature: define HAZARD_FORWARDING_EN for the forwarding-aware hazard rule and live fwd outputs.

module hazard_src_lookup #(
  parameter int STAGES = 3,
  parameter int RW     = 5,
  parameter int SW     = $clog2(STAGES+1)
) (
  input  logic [STAGES-1:0]         i_vld,
  input  logic [STAGES-1:0][RW-1:0] i_dst,
  input  logic [STAGES-1:0][SW-1:0] i_rdy,
  input  logic [RW-1:0]             i_src,
  input  logic [SW-1:0]             i_use,
  input  logic                      i_req,
  output logic                      o_haz,
  output logic                      o_hit,
  output logic [SW-1:0]             o_slot
);
  localparam logic [SW-1:0] LAST = SW'(STAGES-1);

  logic          w_found;
  logic [SW-1:0] w_k;
  logic [SW-1:0] w_rdy;

  // Scan oldest to youngest so the lowest matching slot wins.
  always_comb begin
    w_found = 1'b0;
    w_k     = '0;
    w_rdy   = '0;
    for (int k = STAGES-1; k >= 0; k--) begin
      if (i_req && i_src != '0 && i_vld[k] && i_dst[k] == i_src) begin
        w_found = 1'b1;
        w_k     = SW'(k);
        w_rdy   = i_rdy[k];
      end
    end
  end

`ifdef HAZARD_FORWARDING_EN
  // The oldest slot is always forwardable thanks to GRF write-through.
  assign o_haz  = w_found && (w_k != LAST) &&
                  (({1'b0, w_k} + {1'b0, i_use}) < {1'b0, w_rdy});
  assign o_hit  = w_found && ((w_k == LAST) || (w_k >= w_rdy));
  assign o_slot = w_found ? (w_k + SW'(1)) : '0;
`else
  logic w_unused;
  assign w_unused = ^{i_use, i_rdy, w_rdy};
  assign o_haz  = w_found && (w_k != LAST);
  assign o_hit  = 1'b0;
  assign o_slot = '0;
`endif
endmodule

module hazard_scoreboard #(
  parameter int STAGES = 3,
  parameter int RW     = 5,
  parameter int SW     = $clog2(STAGES+1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          issueValid,
  input  logic          hold,
  input  logic [RW-1:0] dest,
  input  logic [SW-1:0] readyAt,
  input  logic [RW-1:0] src1,
  input  logic [RW-1:0] src2,
  input  logic [SW-1:0] use1,
  input  logic [SW-1:0] use2,
  input  logic          req1,
  input  logic          req2,
  output logic          stall,
  output logic          fwdHit1,
  output logic          fwdHit2,
  output logic [SW-1:0] fwdSlot1,
  output logic [SW-1:0] fwdSlot2,
  output logic [31:0]   stallCount
);
  logic [STAGES-1:0]         r_vld;
  logic [STAGES-1:0][RW-1:0] r_dst;
  logic [STAGES-1:0][SW-1:0] r_rdy;
  logic [31:0]               r_stallCount;

  logic [1:0][RW-1:0] w_src;
  logic [1:0][SW-1:0] w_use;
  logic [1:0]         w_req;
  logic [1:0]         w_haz;
  logic [1:0]         w_hit;
  logic [1:0][SW-1:0] w_slot;

  assign w_src = {src2, src1};
  assign w_use = {use2, use1};
  assign w_req = {req2, req1};

  for (genvar g = 0; g < 2; g++) begin : g_src
    hazard_src_lookup #(.STAGES(STAGES), .RW(RW), .SW(SW)) u_lookup (
      .i_vld  (r_vld),
      .i_dst  (r_dst),
      .i_rdy  (r_rdy),
      .i_src  (w_src[g]),
      .i_use  (w_use[g]),
      .i_req  (w_req[g]),
      .o_haz  (w_haz[g]),
      .o_hit  (w_hit[g]),
      .o_slot (w_slot[g])
    );
  end

  assign stall      = |w_haz;
  assign fwdHit1    = w_hit[0];
  assign fwdHit2    = w_hit[1];
  assign fwdSlot1   = w_slot[0];
  assign fwdSlot2   = w_slot[1];
  assign stallCount = r_stallCount;

  // A stalled D instruction enters E as a bubble; hold freezes everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld        <= '0;
      r_dst        <= '0;
      r_rdy        <= '0;
      r_stallCount <= '0;
    end else if (!hold) begin
      for (int k = STAGES-1; k >= 1; k--) begin
        r_vld[k] <= r_vld[k-1];
        r_dst[k] <= r_dst[k-1];
        r_rdy[k] <= r_rdy[k-1];
      end
      r_vld[0] <= issueValid && !stall && (dest != '0);
      r_dst[0] <= dest;
      r_rdy[0] <= readyAt;
      if (stall && r_stallCount != 32'hFFFF_FFFF)
        r_stallCount <= r_stallCount + 32'd1;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (STAGES=3); expectations switch on HAZARD_FORWARDING_EN.
module tb_hazard_scoreboard;
`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        issueValid = 1'b0, hold = 1'b0;
  logic [4:0]  dest = '0, src1 = '0, src2 = '0;
  logic [1:0]  readyAt = '0, use1 = '0, use2 = '0;
  logic        req1 = 1'b0, req2 = 1'b0;
  logic        stall, fwdHit1, fwdHit2;
  logic [1:0]  fwdSlot1, fwdSlot2;
  logic [31:0] stallCount;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard #(.STAGES(3), .RW(5)) dut (
    .clk(clk), .reset_n(reset_n), .issueValid(issueValid), .hold(hold),
    .dest(dest), .readyAt(readyAt), .src1(src1), .src2(src2),
    .use1(use1), .use2(use2), .req1(req1), .req2(req2),
    .stall(stall), .fwdHit1(fwdHit1), .fwdHit2(fwdHit2),
    .fwdSlot1(fwdSlot1), .fwdSlot2(fwdSlot2), .stallCount(stallCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setD(input logic v, input logic [4:0] d, input logic [1:0] ra,
                      input logic [4:0] s1, input logic [1:0] u1, input logic r1,
                      input logic [4:0] s2, input logic [1:0] u2, input logic r2);
    issueValid = v; dest = d; readyAt = ra;
    src1 = s1; use1 = u1; req1 = r1;
    src2 = s2; use2 = u2; req2 = r2;
    #1;
  endtask

  task automatic issue(input logic [4:0] d, input logic [1:0] ra);
    setD(1'b1, d, ra, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0);
  endtask

  task automatic bubble();
    setD(1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_stall", stall, 0);
    chk("rst_slot1", fwdSlot1, 0);
    chk("rst_count", stallCount, 0);
    reset_n = 1'b1;

    // Fill all slots, then reset asynchronously mid-cycle
    issue(5'd1, 2'd1); tick();
    issue(5'd2, 2'd1); tick();
    issue(5'd3, 2'd1); tick();
    setD(1'b1, 5'd4, 2'd1, 5'd3, 2'd1, 1'b1, 5'd0, 2'd0, 1'b0);
    chk("full_stall", stall, FWD ? 0 : 1);
    chk("full_slot1", fwdSlot1, FWD ? 1 : 0);
    reset_n = 1'b0;
    #1;
    chk("async_stall", stall, 0);
    chk("async_slot1", fwdSlot1, 0);
    chk("async_hit1", fwdHit1, 0);
    tick();
    reset_n = 1'b1;
    bubble();
    chk("async_count", stallCount, 0);
    issue(5'd8, 2'd1);
    chk("post_rst_issue", stall, 0);
    tick();

    // ALU r8 then a use=1 reader
    setD(1'b1, 5'd20, 2'd1, 5'd8, 2'd1, 1'b1, 5'd0, 2'd0, 1'b0);
    chk("alu_stall0", stall, FWD ? 0 : 1);
    chk("alu_slot0", fwdSlot1, FWD ? 1 : 0);
    chk("alu_hit0", fwdHit1, 0);
    tick();
    chk("alu_stall1", stall, FWD ? 0 : 1);
    chk("alu_slot1", fwdSlot1, FWD ? 2 : 0);
    chk("alu_hit1", fwdHit1, FWD ? 1 : 0);
    tick();
    bubble();
    chk("alu_count", stallCount, FWD ? 0 : 2);
    repeat (3) tick();

    // Load r9 then beq (use=0)
    issue(5'd9, 2'd2); tick();
    setD(1'b1, 5'd0, 2'd0, 5'd9, 2'd0, 1'b1, 5'd0, 2'd0, 1'b0);
    chk("ld_beq_stall0", stall, 1);
    tick();
    chk("ld_beq_stall1", stall, 1);
    tick();
    chk("ld_beq_stall2", stall, 0);
    chk("ld_beq_slot", fwdSlot1, FWD ? 3 : 0);
    chk("ld_beq_hit", fwdHit1, FWD ? 1 : 0);
    chk("ld_beq_count", stallCount, FWD ? 2 : 4);
    bubble();
    repeat (3) tick();

    // r0 write, then two writes to r10; youngest wins, r0 never matches
    issue(5'd0, 2'd1); tick();
    issue(5'd10, 2'd1); tick();
    issue(5'd10, 2'd1); tick();
    setD(1'b1, 5'd0, 2'd0, 5'd10, 2'd1, 1'b1, 5'd0, 2'd0, 1'b1);
    chk("young_stall", stall, FWD ? 0 : 1);
    chk("young_slot1", fwdSlot1, FWD ? 1 : 0);
    chk("r0_slot2", fwdSlot2, 0);
    chk("r0_hit2", fwdHit2, 0);
    setD(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 5'd0, 2'd0, 1'b1);
    chk("r0_stall", stall, 0);
    bubble();
    repeat (3) tick();

    // Load r11 then dependent add under hold
    issue(5'd11, 2'd2); tick();
    hold = 1'b1;
    setD(1'b1, 5'd22, 2'd1, 5'd11, 2'd1, 1'b1, 5'd0, 2'd0, 1'b0);
    chk("hold_stall0", stall, 1);
    repeat (5) tick();
    chk("hold_stall5", stall, 1);
    chk("hold_count", stallCount, FWD ? 2 : 4);
    chk("hold_slot1", fwdSlot1, FWD ? 1 : 0);
    hold = 1'b0;
    #1;
    tick();
    chk("unhold_stall", stall, FWD ? 0 : 1);
`ifndef HAZARD_FORWARDING_EN
    tick();
`endif
    chk("unhold_stall_end", stall, 0);
    chk("unhold_count", stallCount, FWD ? 3 : 6);
    chk("unhold_slot1", fwdSlot1, FWD ? 2 : 0);
    bubble();
    repeat (3) tick();

    // ALU r12 then dependent add on src2
    issue(5'd12, 2'd1); tick();
    setD(1'b1, 5'd21, 2'd1, 5'd0, 2'd0, 1'b0, 5'd12, 2'd1, 1'b0);
    chk("req_off_stall", stall, 0);
    setD(1'b1, 5'd21, 2'd1, 5'd0, 2'd0, 1'b0, 5'd12, 2'd1, 1'b1);
    chk("s2_stall0", stall, FWD ? 0 : 1);
    chk("s2_slot0", fwdSlot2, FWD ? 1 : 0);
    chk("s2_hit0", fwdHit2, 0);
    tick();
    chk("s2_stall1", stall, FWD ? 0 : 1);
    chk("s2_slot1", fwdSlot2, FWD ? 2 : 0);
    chk("s2_hit1", fwdHit2, FWD ? 1 : 0);
    tick();
    chk("s2_stall2", stall, 0);
    chk("s2_slot2", fwdSlot2, FWD ? 3 : 0);
    chk("s2_hit2", fwdHit2, FWD ? 1 : 0);
    chk("s2_count", stallCount, FWD ? 3 : 8);
    bubble();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
